// File: rtl/gpr_wb_if.sv
// gpr_wb_if
//   Bundles the write-back request channels of the three result producers
//   (ALU, MEM, CSR), the issue-stage reservation and read-check ports, and
//   the registered GPR write port.
//   Modports:
//     master - producers / issue stage / GPR side (drives requests, observes
//              readies, hazard and the GPR write port)
//     slave  - the write-back arbiter itself
//   Parameters: DW data width, AW register address width.
interface gpr_wb_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic          alu_valid;
  logic [AW-1:0] alu_rd;
  logic [DW-1:0] alu_data;
  logic          alu_ready;

  logic          mem_valid;
  logic [AW-1:0] mem_rd;
  logic [DW-1:0] mem_data;
  logic          mem_ready;

  logic          csr_valid;
  logic [AW-1:0] csr_rd;
  logic [DW-1:0] csr_data;
  logic          csr_ready;

  logic          rsv_valid;
  logic [AW-1:0] rsv_rd;
  logic [AW-1:0] chk_ra;
  logic [AW-1:0] chk_rb;
  logic          hazard;

  logic          gpr_we;
  logic [AW-1:0] gpr_rd;
  logic [DW-1:0] gpr_di;
  logic [1:0]    gpr_src;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output mem_valid, mem_rd, mem_data,
    output csr_valid, csr_rd, csr_data,
    output rsv_valid, rsv_rd, chk_ra, chk_rb,
    input  alu_ready, mem_ready, csr_ready,
    input  hazard, gpr_we, gpr_rd, gpr_di, gpr_src
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  mem_valid, mem_rd, mem_data,
    input  csr_valid, csr_rd, csr_data,
    input  rsv_valid, rsv_rd, chk_ra, chk_rb,
    output alu_ready, mem_ready, csr_ready,
    output hazard, gpr_we, gpr_rd, gpr_di, gpr_src
  );
endinterface

// File: rtl/gpr_wb_arbiter.sv
// gpr_wb_arbiter
//   Round-robin write-back arbiter for the single GPR write port plus a
//   one-bit-per-register busy scoreboard.
//   Ports:
//     clk   - clock, all state updates on the rising edge
//     rst_n - synchronous active-low reset
//     bus   - gpr_wb_if.slave: producer valid/rd/data in, ready out;
//             rsv_valid/rsv_rd reservation in; chk_ra/chk_rb read check in,
//             hazard out (combinational); gpr_we/gpr_rd/gpr_di/gpr_src out
//             (registered, one cycle after the transfer).
module gpr_wb_arbiter #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input logic     clk,
  input logic     rst_n,
  gpr_wb_if.slave bus
);

  localparam int NREG = 1 << AW;

  // Priority pointer / grant source encoding (also the gpr_src encoding).
  localparam logic [1:0] SRC_ALU = 2'd0;
  localparam logic [1:0] SRC_MEM = 2'd1;
  localparam logic [1:0] SRC_CSR = 2'd2;

  logic [1:0]    ptr_q, ptr_d;
  logic [NREG-1:0] busy_q, busy_d;
  logic          gpr_we_q;
  logic [AW-1:0] gpr_rd_q;
  logic [DW-1:0] gpr_di_q;
  logic [1:0]    gpr_src_q;

  logic [2:0]    req;
  logic          gnt_any;
  logic [1:0]    gnt_src;
  logic [2:0]    gnt;
  logic [AW-1:0] sel_rd;
  logic [DW-1:0] sel_data;

  assign req = {bus.csr_valid, bus.mem_valid, bus.alu_valid};

  // Cyclic search starting at the pointer; readies depend only on valids,
  // the pointer and reset, never on ready itself.
  always_comb begin
    gnt_any = 1'b0;
    gnt_src = SRC_ALU;
    if (rst_n) begin
      case (ptr_q)
        SRC_MEM: begin
          if (req[1])      begin gnt_any = 1'b1; gnt_src = SRC_MEM; end
          else if (req[2]) begin gnt_any = 1'b1; gnt_src = SRC_CSR; end
          else if (req[0]) begin gnt_any = 1'b1; gnt_src = SRC_ALU; end
        end
        SRC_CSR: begin
          if (req[2])      begin gnt_any = 1'b1; gnt_src = SRC_CSR; end
          else if (req[0]) begin gnt_any = 1'b1; gnt_src = SRC_ALU; end
          else if (req[1]) begin gnt_any = 1'b1; gnt_src = SRC_MEM; end
        end
        default: begin
          if (req[0])      begin gnt_any = 1'b1; gnt_src = SRC_ALU; end
          else if (req[1]) begin gnt_any = 1'b1; gnt_src = SRC_MEM; end
          else if (req[2]) begin gnt_any = 1'b1; gnt_src = SRC_CSR; end
        end
      endcase
    end
  end

  assign gnt = gnt_any ? (3'b001 << gnt_src) : 3'b000;
  assign bus.alu_ready = gnt[0];
  assign bus.mem_ready = gnt[1];
  assign bus.csr_ready = gnt[2];

  // Payload of the granted producer.
  always_comb begin
    case (gnt_src)
      SRC_MEM: begin sel_rd = bus.mem_rd; sel_data = bus.mem_data; end
      SRC_CSR: begin sel_rd = bus.csr_rd; sel_data = bus.csr_data; end
      default: begin sel_rd = bus.alu_rd; sel_data = bus.alu_data; end
    endcase
  end

  // Pointer rotates past the winner; scoreboard clear is applied before set
  // so a same-cycle reservation of the written register wins.
  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) begin
      ptr_d = (gnt_src == SRC_CSR) ? SRC_ALU : gnt_src + 2'd1;
    end
    busy_d = busy_q;
    if (gnt_any && sel_rd != '0) begin
      busy_d[sel_rd] = 1'b0;
    end
    if (bus.rsv_valid && bus.rsv_rd != '0) begin
      busy_d[bus.rsv_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Output register: address/data/source hold when nothing transfers;
  // rd=0 transfers load the register but never raise the write enable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q     <= SRC_ALU;
      busy_q    <= '0;
      gpr_we_q  <= 1'b0;
      gpr_rd_q  <= '0;
      gpr_di_q  <= '0;
      gpr_src_q <= SRC_ALU;
    end else begin
      ptr_q    <= ptr_d;
      busy_q   <= busy_d;
      gpr_we_q <= gnt_any && (sel_rd != '0);
      if (gnt_any) begin
        gpr_rd_q  <= sel_rd;
        gpr_di_q  <= sel_data;
        gpr_src_q <= gnt_src;
      end
    end
  end

  assign bus.gpr_we  = gpr_we_q;
  assign bus.gpr_rd  = gpr_rd_q;
  assign bus.gpr_di  = gpr_di_q;
  assign bus.gpr_src = gpr_src_q;

  // Registered busy only, no bypass of same-cycle writes; forced low in reset.
  assign bus.hazard = rst_n &&
                      ((bus.chk_ra != '0 && busy_q[bus.chk_ra]) ||
                       (bus.chk_rb != '0 && busy_q[bus.chk_rb]));

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// tb_gpr_wb_arbiter
//   Directed scenarios followed by randomized producer/reservation traffic.
//   A reference model (pointer + busy array) predicts readies and hazard at
//   each negedge and queues the expected write-port contents; a monitor
//   pops the queue shortly after each rising edge and checks the GPR port.
module tb_gpr_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic [2:0]  vld;
  logic [4:0]  rdIn [3];
  logic [31:0] datIn [3];
  logic        rsvValid;
  logic [4:0]  rsvRd;
  logic [4:0]  chkRa;
  logic [4:0]  chkRb;

  gpr_wb_if #(.DW(32), .AW(5)) bus ();

  assign bus.alu_valid = vld[0];
  assign bus.alu_rd    = rdIn[0];
  assign bus.alu_data  = datIn[0];
  assign bus.mem_valid = vld[1];
  assign bus.mem_rd    = rdIn[1];
  assign bus.mem_data  = datIn[1];
  assign bus.csr_valid = vld[2];
  assign bus.csr_rd    = rdIn[2];
  assign bus.csr_data  = datIn[2];
  assign bus.rsv_valid = rsvValid;
  assign bus.rsv_rd    = rsvRd;
  assign bus.chk_ra    = chkRa;
  assign bus.chk_rb    = chkRb;

  gpr_wb_arbiter #(.DW(32), .AW(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          target;
    bit          we;
    logic [4:0]  rd;
    logic [31:0] di;
    logic [1:0]  src;
  } exp_t;

  exp_t sbq [$];

  int   assertCount = 0;
  int   failCount   = 0;
  int   cyc         = 0;
  bit   monOn       = 0;
  bit   rstSeen     = 0;
  bit   lastXfer [3];
  int   ptrM        = 0;
  bit   busyM [32];

  logic [4:0]  heldRd  = '0;
  logic [31:0] heldDi  = '0;
  logic [1:0]  heldSrc = '0;

  function automatic void checkOutput(string name, logic [63:0] act, logic [63:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endfunction

  always @(posedge clk) cyc++;

  // Reference model: predicts grant and hazard from the current inputs,
  // queues the expected registered write, then advances pointer and busy.
  always @(negedge clk) begin
    logic [2:0] actRdy;
    logic [2:0] expRdy;
    logic       expHaz;
    int         g;
    exp_t       e;
    actRdy = {bus.csr_ready, bus.mem_ready, bus.alu_ready};
    for (int s = 0; s < 3; s++) lastXfer[s] = vld[s] && actRdy[s];
    rstSeen = !rst_n;
    if (!rst_n) begin
      expRdy = 3'b000;
      expHaz = 1'b0;
      ptrM = 0;
      for (int r = 0; r < 32; r++) busyM[r] = 0;
    end else begin
      g = -1;
      for (int k = 0; k < 3; k++) begin
        if (g < 0 && vld[(ptrM + k) % 3]) g = (ptrM + k) % 3;
      end
      expRdy = (g >= 0) ? (3'b001 << g) : 3'b000;
      expHaz = (chkRa != 0 && busyM[chkRa]) || (chkRb != 0 && busyM[chkRb]);
      if (g >= 0) begin
        e.target = cyc + 1;
        e.we     = (rdIn[g] != 0);
        e.rd     = rdIn[g];
        e.di     = datIn[g];
        e.src    = 2'(g);
        sbq.push_back(e);
        ptrM = (g + 1) % 3;
        if (rdIn[g] != 0) busyM[rdIn[g]] = 0;
      end
      if (rsvValid && rsvRd != 0) busyM[rsvRd] = 1;
    end
    if (monOn) begin
      checkOutput("ready", 64'(actRdy), 64'(expRdy));
      checkOutput("hazard", 64'(bus.hazard), 64'(expHaz));
    end
  end

  // Monitor: compares the registered write port against the queue.
  always @(posedge clk) begin
    exp_t e;
    #3;
    if (monOn) begin
      if (rstSeen) begin
        checkOutput("rstWe", 64'(bus.gpr_we), 64'(0));
        checkOutput("rstRd", 64'(bus.gpr_rd), 64'(0));
        checkOutput("rstDi", 64'(bus.gpr_di), 64'(0));
        checkOutput("rstSrc", 64'(bus.gpr_src), 64'(0));
        checkOutput("rstQueue", 64'(sbq.size()), 64'(0));
        sbq.delete();
        heldRd = '0; heldDi = '0; heldSrc = '0;
      end else if (sbq.size() > 0 && sbq[0].target == cyc) begin
        e = sbq.pop_front();
        checkOutput("wrWe", 64'(bus.gpr_we), 64'(e.we));
        checkOutput("wrRd", 64'(bus.gpr_rd), 64'(e.rd));
        checkOutput("wrDi", 64'(bus.gpr_di), 64'(e.di));
        checkOutput("wrSrc", 64'(bus.gpr_src), 64'(e.src));
        heldRd = e.rd; heldDi = e.di; heldSrc = e.src;
      end else begin
        checkOutput("idleWe", 64'(bus.gpr_we), 64'(0));
        checkOutput("holdRd", 64'(bus.gpr_rd), 64'(heldRd));
        checkOutput("holdDi", 64'(bus.gpr_di), 64'(heldDi));
        checkOutput("holdSrc", 64'(bus.gpr_src), 64'(heldSrc));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [2:0] v,
                               input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2,
                               input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                               input logic rv, input logic [4:0] rr,
                               input logic [4:0] ra, input logic [4:0] rb,
                               input logic rstn);
    vld = v;
    rdIn[0] = r0; rdIn[1] = r1; rdIn[2] = r2;
    datIn[0] = d0; datIn[1] = d1; datIn[2] = d2;
    rsvValid = rv; rsvRd = rr;
    chkRa = ra; chkRb = rb;
    rst_n = rstn;
    tick();
  endtask

  task automatic randomCycle();
    for (int s = 0; s < 3; s++) begin
      if (!vld[s] || lastXfer[s]) begin
        vld[s]   = ($urandom_range(0, 99) < 60);
        rdIn[s]  = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
        datIn[s] = $urandom;
      end
    end
    rsvValid = ($urandom_range(0, 99) < 35);
    rsvRd    = 5'($urandom_range(0, 7));
    chkRa    = 5'($urandom_range(0, 8));
    chkRb    = 5'($urandom_range(0, 31));
    rst_n    = ($urandom_range(0, 199) != 0);
    tick();
  endtask

  initial begin
    vld = 3'b000;
    for (int s = 0; s < 3; s++) begin rdIn[s] = '0; datIn[s] = '0; lastXfer[s] = 0; end
    for (int r = 0; r < 32; r++) busyM[r] = 0;
    rsvValid = 1'b0; rsvRd = '0; chkRa = '0; chkRb = '0;
    rst_n = 1'b0;
    tick();
    tick();
    monOn = 1;
    tick();

    $display("[TB] single ALU write");
    applyStimulus(3'b001, 5'd5, 5'd0, 5'd0, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    $display("[TB] back-to-back round robin");
    applyStimulus(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++)
      applyStimulus(3'b111, 5'd1, 5'd2, 5'd3, 32'h100 + i, 32'h200 + i, 32'h300 + i, 0, 0, 0, 0, 1);
    applyStimulus(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    $display("[TB] reservation and clear");
    applyStimulus(3'b000, 0, 0, 0, 0, 0, 0, 1, 5'd7, 0, 0, 1);
    applyStimulus(3'b010, 0, 5'd7, 0, 0, 32'h77, 0, 0, 0, 5'd7, 0, 1);
    applyStimulus(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 5'd7, 0, 1);

    $display("[TB] set wins over same-cycle clear");
    applyStimulus(3'b000, 0, 0, 0, 0, 0, 0, 1, 5'd9, 0, 5'd9, 1);
    applyStimulus(3'b100, 0, 0, 5'd9, 0, 0, 32'h99, 1, 5'd9, 0, 5'd9, 1);
    applyStimulus(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd9, 1);
    applyStimulus(3'b100, 0, 0, 5'd9, 0, 0, 32'h98, 0, 0, 0, 5'd9, 1);
    applyStimulus(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd9, 1);

    $display("[TB] rd=0 transfer");
    applyStimulus(3'b011, 5'd0, 5'd4, 0, 32'h1234, 32'h4444, 0, 1, 5'd0, 0, 0, 1);
    applyStimulus(3'b011, 5'd6, 5'd4, 0, 32'h6666, 32'h4444, 0, 0, 0, 5'd0, 0, 1);
    applyStimulus(3'b001, 5'd6, 0, 0, 32'h6666, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    $display("[TB] reset mid-operation");
    applyStimulus(3'b000, 0, 0, 0, 0, 0, 0, 1, 5'd12, 0, 0, 1);
    applyStimulus(3'b100, 0, 0, 5'd3, 0, 0, 32'hC5C5, 0, 0, 5'd12, 0, 0);
    applyStimulus(3'b111, 5'd1, 5'd2, 5'd3, 32'hA1, 32'hA2, 32'hA3, 0, 0, 5'd12, 0, 1);
    applyStimulus(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 2000; i++) randomCycle();

    rst_n = 1'b1;
    vld = 3'b000;
    rsvValid = 1'b0;
    tick();
    tick();
    tick();
    checkOutput("sbDrain", 64'(sbq.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/gpr_wb_arbiter.md
# gpr_wb_arbiter

Write-back arbiter and register scoreboard for the general-purpose register file. Three result producers (ALU, MEM, CSR) compete for the single GPR write port. The block grants one producer per cycle in round-robin order and drives registered write enable, address and data into the GPR. A 32-entry busy scoreboard marks reserved destinations and raises a hazard flag for read-port addresses that are still pending.

## Interface
- DW, 32, data width of write-back path
- AW, 5, register address width (32 registers; x0 hard-wired zero)

- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- alu_valid  in  1  ALU result available
- alu_rd  in  AW  ALU destination
- alu_data  in  DW  ALU result
- alu_ready  out  1  ALU request granted this cycle
- mem_valid / mem_rd / mem_data / mem_ready  same as ALU group, MEM producer
- csr_valid / csr_rd / csr_data / csr_ready  same as ALU group, CSR producer
- rsv_valid  in  1  issue stage reserves a destination
- rsv_rd  in  AW  reserved destination
- chk_ra  in  AW  read address, port a
- chk_rb  in  AW  read address, port b
- hazard  out  1  port a or port b address is busy (combinational)
- gpr_we  out  1  GPR write enable (registered)
- gpr_rd  out  AW  GPR write address (registered)
- gpr_di  out  DW  GPR write data (registered)
- gpr_src  out  2  source of current write: 0 ALU, 1 MEM, 2 CSR (registered)

## Operation
- Handshake: a transfer happens when x_valid & x_ready. Ready is combinational from the valids and the priority pointer, and must not depend on ready itself. Producers hold valid, rd and data stable until the transfer.
- Arbitration: at most one ready is high per cycle. The priority pointer `ptr` ∈ {ALU, MEM, CSR} selects the first requester checked, and the search proceeds cyclically ALU→MEM→CSR→ALU.
- After a grant to source s, ptr ← s+1 (mod 3). With no grant, ptr is held.
- While rst_n=0, all readies are 0.
- Output register update:
  - On a transfer from s: gpr_we ← (rd≠0), gpr_rd ← rd, gpr_di ← data, gpr_src ← s.
  - With no transfer: gpr_we ← 0, and gpr_rd, gpr_di and gpr_src hold their values.
- rd=0 transfers are accepted normally and consume the grant and rotate ptr, but never assert gpr_we.
- Scoreboard `busy[31:0]`:
  - busy[0] is constant 0.
  - Set: rsv_valid & rsv_rd≠0 sets busy[rsv_rd] at the edge.
  - Clear: a transfer with rd≠0 clears busy[rd] at the same edge that loads the output register.
  - If set and clear target the same rd in the same cycle, set wins.
  - A write to a non-busy register is legal and leaves busy unchanged.
- hazard = (chk_ra≠0 & busy[chk_ra]) | (chk_rb≠0 & busy[chk_rb]). It reflects the registered busy only; there is no bypass from same-cycle transfers.
- Busy is a single bit per register: one write clears it regardless of how many reservations were made. Issue must stall on hazard for its own rd before reserving it again.

## Timing
- Reset values: gpr_we=0, gpr_rd=0, gpr_di=0, gpr_src=0, ptr=ALU, busy=0. Readies are 0 during reset and hazard evaluates to 0.
- Latency: a transfer in cycle N gives gpr_we/rd/di/src valid throughout cycle N+1, i.e. one write per cycle sustained.
- GPR consumption: gpr_we is high for exactly one cycle per accepted rd≠0 transfer. The GPR latches it within that cycle.
- Scoreboard timing: the busy clear is visible on hazard in cycle N+1, the same cycle the GPR write occurs. A reservation in cycle N is visible from cycle N+1.
- Reset mid-operation: a transfer in the cycle where rst_n=0 is not accepted. Output and busy are cleared at that edge, and any write that was presented in the prior cycle still completes in the current cycle (no retraction).
- Back-to-back: continuous valids from all three sources give a grant pattern of ALU, MEM, CSR, ALU… with gpr_we held high.

## Test plan
- Reset, then alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF → alu_ready=1 in the same cycle; next cycle gpr_we=1, gpr_rd=5, gpr_di=0xDEADBEEF, gpr_src=0; following cycle gpr_we=0.
- All three valid continuously for 6 cycles (rd 1/2/3) → grants ALU, MEM, CSR, ALU, MEM, CSR; only one ready per cycle; gpr_src sequence 0,1,2,0,1,2.
- rsv_valid, rsv_rd=7; next cycle chk_ra=7 → hazard=1. mem writes rd=7 → hazard stays 1 in the transfer cycle and is 0 in the cycle after.
- Same cycle: rsv_rd=9 with csr transfer rd=9, while busy[9]=1 → busy[9] remains 1 and hazard with chk_rb=9 stays 1.
- alu transfer with rd=0 and data 0x1234 → gpr_we stays 0, ptr advances so a simultaneous-pending MEM request is granted next; chk_ra=0 after rsv_rd=0 → hazard=0.
- Assert rst_n=0 for one cycle while csr_valid=1 → csr_ready=0; after reset gpr_we=0, busy all clear, and the first grant goes to ALU when all valids are high.
